uart_rx: RTL

Serial receive front end for the core's UART RX pin. Synchronises the raw `i_rx` line, detects and validates 8N1 frames (optional even parity), and buffers received bytes in a small FIFO. The core's UART peripheral pops bytes through a valid/ready handshake. One instance per UART, in the `i_clk` domain.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state enum, frame width and default bit timing.
// UART_RX_PARITY_EN adds the PARITY state to the receive FSM.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 250;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; head entry is always presented on rdata.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, 8N1 frame FSM with error flags, byte FIFO with valid/ready pop.
// Define UART_RX_PARITY_EN for 8E1 frames and a live o_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rx,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_frame_err,
    output logic                      o_overrun,
    output logic                      o_parity_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    logic                      sync1_q, rx_s_q, rx_s_d_q;
    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      push_c, pop_c;
    logic                      fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                      par_err_q, par_err_d;
    logic                      parity_err_q, parity_err_d;
`endif

    assign pop_c   = !fifo_empty && i_ready;
    assign o_valid = !fifo_empty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d    = par_err_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_s_d_q && !rx_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    par_err_d = (rx_s_q != ^shift_q);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                // Frame error wins over parity error; only clean frames reach the FIFO.
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_err_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        push_c    = 1'b1;
                        overrun_d = fifo_full && !pop_c;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_s_d_q    <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= i_rx;
            rx_s_q      <= sync1_q;
            rx_s_d_q    <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= par_err_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_c),
        .wdata (shift_q),
        .pop   (pop_c),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
